// File: rtl/accum_chain_if.sv
// Control and result bundle for the accumulator chain.
// The chain drives the results; the controller drives everything else.
interface accum_chain_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
);
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      EN;
  logic                      CLR;
  logic                      LOAD;
  logic [SW-1:0]             LOAD_SEL;
  logic [WIDTH-1:0]          LOAD_VAL;
  logic [CHANNELS*WIDTH-1:0] STEP;
  logic                      OVF_CLR;
  logic [CHANNELS*WIDTH-1:0] out;
  logic [CHANNELS-1:0]       wrap;
  logic [CHANNELS-1:0]       ovf;

  modport master (
    output EN, CLR, LOAD, LOAD_SEL, LOAD_VAL, STEP, OVF_CLR,
    input  out, wrap, ovf
  );

  modport slave (
    input  EN, CLR, LOAD, LOAD_SEL, LOAD_VAL, STEP, OVF_CLR,
    output out, wrap, ovf
  );
endinterface

// File: rtl/accum_chain.sv
// Chain of accumulating counters; each channel adds its step
// plus the registered value of its predecessor.
module accum_chain #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int SATURATE = 0
) (
  input  logic         CLK,
  input  logic         RST,
  accum_chain_if.slave bus
);
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0][WIDTH-1:0] acc;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH+1:0] pred;
    logic [WIDTH+1:0] sum;
    logic             hit;
    logic             over;
    logic             adv_ovf;
    logic             w;
    logic             o;

    // Predecessor term is registered, so no carry chain between channels.
    if (k == 0) begin : g_head
      assign pred = '0;
    end else begin : g_link
      assign pred = {2'b00, acc[k-1]};
    end

    assign sum = {2'b00, c}
               + {2'b00, bus.STEP[k*WIDTH +: WIDTH]}
               + pred;
    assign over = |sum[WIDTH+1:WIDTH];
    assign hit  = bus.LOAD && (bus.LOAD_SEL == SW'(k));
    assign nxt  = (over && (SATURATE != 0)) ? '1 : sum[WIDTH-1:0];
    assign adv_ovf = !bus.CLR && !hit && bus.EN && over;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        c <= '0;
        w <= 1'b0;
        o <= 1'b0;
      end else begin
        w <= adv_ovf;
        if (bus.CLR)      c <= '0;
        else if (hit)     c <= bus.LOAD_VAL;
        else if (bus.EN)  c <= nxt;
        if (adv_ovf)          o <= 1'b1;
        else if (bus.OVF_CLR) o <= 1'b0;
      end
    end

    assign acc[k]      = c;
    assign bus.wrap[k] = w;
    assign bus.ovf[k]  = o;
  end

  assign bus.out = acc;
endmodule

// File: tb/tb_accum_chain.sv
// Directed bench for accum_chain across wrap, saturate,
// reference and three-channel configurations.
module tb_accum_chain;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  accum_chain_if #(.WIDTH(32), .CHANNELS(2)) rb ();
  accum_chain_if #(.WIDTH(8),  .CHANNELS(1)) wb ();
  accum_chain_if #(.WIDTH(8),  .CHANNELS(1)) sb ();
  accum_chain_if #(.WIDTH(8),  .CHANNELS(3)) tb3 ();

  accum_chain #(.WIDTH(32), .CHANNELS(2), .SATURATE(0))
    u_ref (.CLK(CLK), .RST(RST), .bus(rb));
  accum_chain #(.WIDTH(8), .CHANNELS(1), .SATURATE(0))
    u_wrap (.CLK(CLK), .RST(RST), .bus(wb));
  accum_chain #(.WIDTH(8), .CHANNELS(1), .SATURATE(1))
    u_sat (.CLK(CLK), .RST(RST), .bus(sb));
  accum_chain #(.WIDTH(8), .CHANNELS(3), .SATURATE(0))
    u_tri (.CLK(CLK), .RST(RST), .bus(tb3));

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic ref_chk(input string tag,
                         input logic [31:0] e0,
                         input logic [31:0] e1);
    chk({tag, "_c0"}, 64'(rb.out[31:0]), 64'(e0));
    chk({tag, "_c1"}, 64'(rb.out[63:32]), 64'(e1));
  endtask

  initial begin
    rb.EN = 0; rb.CLR = 0; rb.LOAD = 0; rb.LOAD_SEL = '0;
    rb.LOAD_VAL = '0; rb.STEP = '0; rb.OVF_CLR = 0;
    wb.EN = 0; wb.CLR = 0; wb.LOAD = 0; wb.LOAD_SEL = '0;
    wb.LOAD_VAL = '0; wb.STEP = '0; wb.OVF_CLR = 0;
    sb.EN = 0; sb.CLR = 0; sb.LOAD = 0; sb.LOAD_SEL = '0;
    sb.LOAD_VAL = '0; sb.STEP = '0; sb.OVF_CLR = 0;
    tb3.EN = 0; tb3.CLR = 0; tb3.LOAD = 0; tb3.LOAD_SEL = '0;
    tb3.LOAD_VAL = '0; tb3.STEP = '0; tb3.OVF_CLR = 0;

    #2;
    chk("rst_out", 64'(rb.out), 64'h0);
    chk("rst_wrap", 64'(rb.wrap), 64'h0);
    chk("rst_ovf", 64'(rb.ovf), 64'h0);
    step();
    step();
    RST = 1'b1;

    // Reference chain: steps 2 / 1
    rb.STEP = {32'd1, 32'd2};
    rb.EN = 1;
    step(); ref_chk("ref1", 32'd2, 32'd1);
    step(); ref_chk("ref2", 32'd4, 32'd4);
    step(); ref_chk("ref3", 32'd6, 32'd9);
    step(); ref_chk("ref4", 32'd8, 32'd16);
    chk("ref_wrap", 64'(rb.wrap), 64'h0);
    chk("ref_ovf", 64'(rb.ovf), 64'h0);

    rb.EN = 0;
    step(); ref_chk("hold", 32'd8, 32'd16);
    chk("hold_wrap", 64'(rb.wrap), 64'h0);

    // CLR beats LOAD
    rb.EN = 1; rb.CLR = 1; rb.LOAD = 1;
    rb.LOAD_SEL = 1'b0; rb.LOAD_VAL = 32'd55;
    step(); ref_chk("clr_load", 32'd0, 32'd0);
    rb.CLR = 0; rb.LOAD = 0;
    step(); ref_chk("adv1", 32'd2, 32'd1);
    step(); ref_chk("adv2", 32'd4, 32'd4);
    rb.LOAD = 1; rb.LOAD_SEL = 1'b1; rb.LOAD_VAL = 32'd100;
    step(); ref_chk("load1", 32'd6, 32'd100);
    rb.LOAD = 0;
    step(); ref_chk("post_load", 32'd8, 32'd107);

    // Asynchronous reset between edges
    #2 RST = 1'b0;
    #1;
    ref_chk("async", 32'd0, 32'd0);
    chk("async_wrap", 64'(rb.wrap), 64'h0);
    step(); ref_chk("async_hold", 32'd0, 32'd0);
    RST = 1'b1;
    step(); ref_chk("restart1", 32'd2, 32'd1);
    step(); ref_chk("restart2", 32'd4, 32'd4);
    rb.EN = 0;

    // Wrap mode, single channel, step 2
    wb.STEP = 8'd2;
    wb.LOAD = 1; wb.LOAD_VAL = 8'hFE;
    step();
    chk("w_load", 64'(wb.out), 64'hFE);
    chk("w_load_wrap", 64'(wb.wrap), 64'h0);
    wb.LOAD = 0; wb.EN = 1;
    step();
    chk("w_ovf_out", 64'(wb.out), 64'h00);
    chk("w_ovf_wrap", 64'(wb.wrap), 64'h1);
    chk("w_ovf_flag", 64'(wb.ovf), 64'h1);
    step();
    chk("w_next_out", 64'(wb.out), 64'h02);
    chk("w_next_wrap", 64'(wb.wrap), 64'h0);
    chk("w_next_ovf", 64'(wb.ovf), 64'h1);
    wb.EN = 0;
    step();
    chk("w_hold_ovf", 64'(wb.ovf), 64'h1);
    wb.OVF_CLR = 1;
    step();
    chk("w_ovfclr", 64'(wb.ovf), 64'h0);
    wb.OVF_CLR = 0;

    // OVF_CLR and overflow on the same edge: set wins
    wb.LOAD = 1; wb.LOAD_VAL = 8'hFE;
    step();
    wb.LOAD = 0; wb.EN = 1; wb.OVF_CLR = 1;
    step();
    chk("w_setwin_ovf", 64'(wb.ovf), 64'h1);
    chk("w_setwin_out", 64'(wb.out), 64'h00);
    wb.OVF_CLR = 0; wb.CLR = 1;
    step();
    chk("w_clr_out", 64'(wb.out), 64'h00);
    chk("w_clr_wrap", 64'(wb.wrap), 64'h0);
    chk("w_clr_ovf", 64'(wb.ovf), 64'h1);
    wb.CLR = 0; wb.EN = 0; wb.OVF_CLR = 1;
    step();
    chk("w_clr2_ovf", 64'(wb.ovf), 64'h0);
    wb.OVF_CLR = 0;

    // Saturate mode
    sb.STEP = 8'd2;
    sb.LOAD = 1; sb.LOAD_VAL = 8'hFE;
    step();
    sb.LOAD = 0; sb.EN = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("s_out%0d", i), 64'(sb.out), 64'hFF);
      chk($sformatf("s_wrap%0d", i), 64'(sb.wrap), 64'h1);
      chk($sformatf("s_ovf%0d", i), 64'(sb.ovf), 64'h1);
    end
    sb.EN = 0;

    // Three channels: out-of-range select ignored
    tb3.STEP = {8'd1, 8'd1, 8'd1};
    tb3.EN = 1; tb3.LOAD = 1;
    tb3.LOAD_SEL = 2'd3; tb3.LOAD_VAL = 8'd77;
    step();
    chk("t_badsel", 64'(tb3.out), 64'h010101);
    tb3.LOAD_SEL = 2'd2; tb3.LOAD_VAL = 8'd50;
    step();
    chk("t_load2", 64'(tb3.out), 64'h320302);
    tb3.LOAD = 0; tb3.EN = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
